draw_sprite: RTL and testbench
==============================

Name: draw_sprite

Overview:
- Parametrised successor to the fixed 64x64 rectangle drawer in the VGA overlay chain.
- Overlays a WIDTH x HEIGHT texture, read from an external synchronous ROM, onto the incoming VGA timing/colour bus.
- Adds integer scaling, X/Y mirroring, a configurable transparent colour, frame-synchronous position latching and a ROM-latency-matched pipeline.
- Sits between background/earlier overlay stages and the VGA output stage; instances chain like other draw stages.

Parameters:
- WIDTH_LOG2, 6, log2 of sprite width in texels (width = 2^WIDTH_LOG2)
- HEIGHT_LOG2, 6, log2 of sprite height in texels
- ROM_LAT, 1, ROM read latency in pclk cycles (1..4)
- TRANSP_EN, 1, 1 = texels equal to TRANSP_RGB are not drawn
- TRANSP_RGB, 12'h0FF, transparent colour key

Ports:
- pclk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- hcount_in  in  11  horizontal counter
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- vcount_in  in  11  vertical counter
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  upstream colour
- xpos  in  12  sprite left edge (screen px)
- ypos  in  12  sprite top edge
- scale  in  2  magnification = 2^scale (1,2,4,8)
- mirror_x  in  1  horizontal flip
- mirror_y  in  1  vertical flip
- enable  in  1  sprite visible
- rgb_pixel  in  12  ROM data
- pixel_addr  out  HEIGHT_LOG2+WIDTH_LOG2  ROM address {v,u}
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  delayed timing
- rgb_out  out  12  composited colour
- hit  out  1  opaque sprite texel drawn this pixel (aligned with rgb_out)

Behaviour:
- One clock, pclk; reset rst is asynchronous and active-low. When rst is low, all outputs, shadows and pipeline stages are 0 (enable shadow 0, so no sprite is drawn).
- Shadow registers: xpos, ypos, scale, mirror_x, mirror_y and enable are captured only on the vblnk_in rising edge, detected against registered vblnk_in.
  - Input changes mid-frame have no effect until the next frame.
  - The first capture after reset is at the first vblnk_in rising edge.
- Hit test (stage 0, combinational on inputs):
  - dx = {1'b0,hcount_in} - xs and dy = {1'b0,vcount_in} - ys, 13-bit.
  - in_rect = enable_s && hcount_in >= xs && dx < (2^WIDTH_LOG2 << scale_s) && vcount_in >= ys && dy < (2^HEIGHT_LOG2 << scale_s) && !hblnk_in && !vblnk_in.
  - Bounds are half-open (exactly W*2^scale by H*2^scale pixels).
  - Comparisons are 13-bit; xs + extent overflowing 11 bits simply clips at the screen edge.
- Address (stage 1, registered):
  - u = dx >> scale_s (low WIDTH_LOG2 bits); if mirror_x, u = 2^WIDTH_LOG2-1-u. v is the same using dy and mirror_y.
  - pixel_addr = {v,u} when in_rect, else 0.
- ROM data for the stage-1 address arrives ROM_LAT cycles later.
- Delay line: timing signals, rgb_in and in_rect are delayed by ROM_LAT+1 cycles, then output-registered.
  - Total latency input to output is ROM_LAT+2 cycles (3 by default) for every output.
- Composite (output register):
  - draw = in_rect_d && !(TRANSP_EN && rgb_pixel == TRANSP_RGB).
  - rgb_out = draw ? rgb_pixel : rgb_in_d; hit = draw.
- Sprite partly off-screen (xs > 1023 or ys > 767): it is clipped naturally. xs >= 2048 never hits.
- Reset deasserted mid-frame: the pipeline refills with blanking-safe zeros; no drawing until the first capture.

Test Plan:
- Default params, xpos=100, ypos=50, scale=0, ROM model returning addr[11:0] as colour: the pixel at (100,50) shows rgb 12'h000 and (163,50) shows 12'h03F. (164,50) and (100,114) show rgb_in. All outputs lag inputs by exactly 3 cycles.
- scale=2: sprite spans x 100..355. Pixels 100..103 share u=0; pixel 104 yields u=1; (356,y) passes rgb_in.
- mirror_x=1, mirror_y=1: (100,50) requests addr 12'hFFF; (163,113) requests 12'h000.
- ROM returns 12'h0FF at an in-rect pixel: rgb_out = rgb_in and hit=0. With TRANSP_EN=0, rgb_out = 12'h0FF and hit=1.
- Change xpos from 100 to 300 mid-frame (vcount=200): the remainder of the frame still draws at 100. The next frame draws at 300 after the vblnk rising edge.
- Assert rst low mid-line: all outputs are 0 immediately (asynchronous). After release, enable stays 0 until the next vblnk edge. Repeat with ROM_LAT=3, checking latency is 5.

Source files
------------

// File: rtl/draw_sprite.sv
// rtl/draw_sprite.sv - textured sprite overlay stage for the VGA draw chain
//
// Overlays a 2^WIDTH_LOG2 x 2^HEIGHT_LOG2 texture, fetched from an external
// synchronous ROM, onto the incoming VGA timing/colour bus. Supports integer
// scaling (2^scale), X/Y mirroring and a transparent colour key. Position and
// mode inputs are latched once per frame on the vblnk_in rising edge.
//
// Ports:
//   pclk, rst                 pixel clock, asynchronous active-low reset
//   hcount_in .. rgb_in       upstream timing and colour
//   xpos, ypos                sprite top-left corner in screen pixels
//   scale                     magnification 2^scale
//   mirror_x, mirror_y        texture flips
//   enable                    sprite visible
//   rgb_pixel                 ROM data, ROM_LAT cycles after pixel_addr
//   pixel_addr                ROM address {v,u}
//   hcount_out .. rgb_out     timing and composited colour, ROM_LAT+2 cycles late
//   hit                       opaque texel drawn on this output pixel
module draw_sprite #(
  parameter int          WIDTH_LOG2  = 6,
  parameter int          HEIGHT_LOG2 = 6,
  parameter int          ROM_LAT     = 1,
  parameter bit          TRANSP_EN   = 1'b1,
  parameter logic [11:0] TRANSP_RGB  = 12'h0FF
) (
  input  logic                              pclk,
  input  logic                              rst,
  input  logic [10:0]                       hcount_in,
  input  logic                              hsync_in,
  input  logic                              hblnk_in,
  input  logic [10:0]                       vcount_in,
  input  logic                              vsync_in,
  input  logic                              vblnk_in,
  input  logic [11:0]                       rgb_in,
  input  logic [11:0]                       xpos,
  input  logic [11:0]                       ypos,
  input  logic [1:0]                        scale,
  input  logic                              mirror_x,
  input  logic                              mirror_y,
  input  logic                              enable,
  input  logic [11:0]                       rgb_pixel,
  output logic [HEIGHT_LOG2+WIDTH_LOG2-1:0] pixel_addr,
  output logic [10:0]                       hcount_out,
  output logic                              hsync_out,
  output logic                              hblnk_out,
  output logic [10:0]                       vcount_out,
  output logic                              vsync_out,
  output logic                              vblnk_out,
  output logic [11:0]                       rgb_out,
  output logic                              hit
);

  // Delay-line word: {hcount, hsync, hblnk, vcount, vsync, vblnk, rgb, in_rect}
  localparam int DW    = 39;
  localparam int DEPTH = ROM_LAT + 1;

  // ---------------------------------------------------------------------------
  // Frame-synchronous shadow registers
  // ---------------------------------------------------------------------------
  logic        vblnk_q;
  logic [11:0] xs;
  logic [11:0] ys;
  logic [1:0]  scale_s;
  logic        mirror_x_s;
  logic        mirror_y_s;
  logic        enable_s;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_q    <= 1'b0;
      xs         <= '0;
      ys         <= '0;
      scale_s    <= '0;
      mirror_x_s <= 1'b0;
      mirror_y_s <= 1'b0;
      enable_s   <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
      if (vblnk_in && !vblnk_q) begin
        xs         <= xpos;
        ys         <= ypos;
        scale_s    <= scale;
        mirror_x_s <= mirror_x;
        mirror_y_s <= mirror_y;
        enable_s   <= enable;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: hit test and texel coordinates
  // ---------------------------------------------------------------------------
  logic [12:0]            dx;
  logic [12:0]            dy;
  logic [12:0]            ext_w;
  logic [12:0]            ext_h;
  logic                   in_rect;
  logic [WIDTH_LOG2-1:0]  u;
  logic [HEIGHT_LOG2-1:0] v;

  always_comb begin
    dx    = {2'b00, hcount_in} - {1'b0, xs};
    dy    = {2'b00, vcount_in} - {1'b0, ys};
    ext_w = 13'(1 << WIDTH_LOG2) << scale_s;
    ext_h = 13'(1 << HEIGHT_LOG2) << scale_s;
    // 13-bit compares: a sprite hanging past the 11-bit screen edge just clips,
    // and xs >= 2048 can never satisfy hcount >= xs.
    in_rect = enable_s
           && ({2'b00, hcount_in} >= {1'b0, xs}) && (dx < ext_w)
           && ({2'b00, vcount_in} >= {1'b0, ys}) && (dy < ext_h)
           && !hblnk_in && !vblnk_in;
    u = WIDTH_LOG2'(dx >> scale_s);
    v = HEIGHT_LOG2'(dy >> scale_s);
    // Bitwise inversion is (2^N - 1 - n) for an N-bit coordinate.
    if (mirror_x_s) u = ~u;
    if (mirror_y_s) v = ~v;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 address register and ROM-latency-matched delay line
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dl [DEPTH];

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
      for (int i = 0; i < DEPTH; i++) dl[i] <= '0;
    end else begin
      pixel_addr <= in_rect ? {v, u} : '0;
      dl[0] <= {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
                rgb_in, in_rect};
      for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
    end
  end

  logic [10:0] hcount_d;
  logic        hsync_d;
  logic        hblnk_d;
  logic [10:0] vcount_d;
  logic        vsync_d;
  logic        vblnk_d;
  logic [11:0] rgb_d;
  logic        in_rect_d;

  assign {hcount_d, hsync_d, hblnk_d, vcount_d, vsync_d, vblnk_d, rgb_d, in_rect_d}
    = dl[DEPTH-1];

  // ---------------------------------------------------------------------------
  // Composite and output register
  // ---------------------------------------------------------------------------
  logic draw;

  assign draw = in_rect_d && !(TRANSP_EN && (rgb_pixel == TRANSP_RGB));

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      hit        <= 1'b0;
    end else begin
      hcount_out <= hcount_d;
      hsync_out  <= hsync_d;
      hblnk_out  <= hblnk_d;
      vcount_out <= vcount_d;
      vsync_out  <= vsync_d;
      vblnk_out  <= vblnk_d;
      rgb_out    <= draw ? rgb_pixel : rgb_d;
      hit        <= draw;
    end
  end

endmodule

// File: tb/tb_draw_sprite.sv
// tb/tb_draw_sprite.sv - scoreboard bench for draw_sprite
module tb_draw_sprite;

  typedef struct {
    int          due;
    logic [63:0] val;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic [10:0] vcount_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  scale;
  logic        mirror_x;
  logic        mirror_y;
  logic        enable;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  exp_t qa[$];
  exp_t q1[$];
  exp_t q3[$];
  exp_t qn[$];

  int m_xs, m_ys, m_sc;
  bit m_mx, m_my, m_en, m_vprev;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Three instances sharing one stimulus stream: default, ROM_LAT=3, no colour key
  logic [11:0] addr1, addr3, addrn;
  logic [11:0] pix1 = '0, pixn = '0;
  logic [11:0] rom3 [3] = '{12'h0, 12'h0, 12'h0};
  logic [10:0] hco1, hco3, hcon, vco1, vco3, vcon;
  logic        hs1, hs3, hsn, hb1, hb3, hbn, vs1, vs3, vsn, vb1, vb3, vbn;
  logic [11:0] rgb1, rgb3, rgbn;
  logic        hit1, hit3, hitn;

  always @(posedge pclk) begin
    pix1    <= addr1;
    pixn    <= addrn;
    rom3[0] <= addr3;
    rom3[1] <= rom3[0];
    rom3[2] <= rom3[1];
  end

  draw_sprite dut1 (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .hsync_in(hsync_in),
    .hblnk_in(hblnk_in), .vcount_in(vcount_in), .vsync_in(vsync_in),
    .vblnk_in(vblnk_in), .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .scale(scale), .mirror_x(mirror_x), .mirror_y(mirror_y), .enable(enable),
    .rgb_pixel(pix1), .pixel_addr(addr1), .hcount_out(hco1), .hsync_out(hs1),
    .hblnk_out(hb1), .vcount_out(vco1), .vsync_out(vs1), .vblnk_out(vb1),
    .rgb_out(rgb1), .hit(hit1)
  );

  draw_sprite #(.ROM_LAT(3)) dut3 (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .hsync_in(hsync_in),
    .hblnk_in(hblnk_in), .vcount_in(vcount_in), .vsync_in(vsync_in),
    .vblnk_in(vblnk_in), .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .scale(scale), .mirror_x(mirror_x), .mirror_y(mirror_y), .enable(enable),
    .rgb_pixel(rom3[2]), .pixel_addr(addr3), .hcount_out(hco3), .hsync_out(hs3),
    .hblnk_out(hb3), .vcount_out(vco3), .vsync_out(vs3), .vblnk_out(vb3),
    .rgb_out(rgb3), .hit(hit3)
  );

  draw_sprite #(.TRANSP_EN(1'b0)) dutn (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .hsync_in(hsync_in),
    .hblnk_in(hblnk_in), .vcount_in(vcount_in), .vsync_in(vsync_in),
    .vblnk_in(vblnk_in), .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .scale(scale), .mirror_x(mirror_x), .mirror_y(mirror_y), .enable(enable),
    .rgb_pixel(pixn), .pixel_addr(addrn), .hcount_out(hcon), .hsync_out(hsn),
    .hblnk_out(hbn), .vcount_out(vcon), .vsync_out(vsn), .vblnk_out(vbn),
    .rgb_out(rgbn), .hit(hitn)
  );

  wire [38:0] bus1 = {hco1, hs1, hb1, vco1, vs1, vb1, rgb1, hit1};
  wire [38:0] bus3 = {hco3, hs3, hb3, vco3, vs3, vb3, rgb3, hit3};
  wire [38:0] busn = {hcon, hsn, hbn, vcon, vsn, vbn, rgbn, hitn};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr1"}, 64'(addr1), 64'd0);
    check({tag, "_addr3"}, 64'(addr3), 64'd0);
    check({tag, "_addrn"}, 64'(addrn), 64'd0);
    check({tag, "_out1"}, 64'(bus1), 64'd0);
    check({tag, "_out3"}, 64'(bus3), 64'd0);
    check({tag, "_outn"}, 64'(busn), 64'd0);
  endtask

  task automatic pop_all();
    exp_t e;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      e = qa.pop_front();
      check("addr_lat1", 64'(addr1), e.val);
      check("addr_lat3", 64'(addr3), e.val);
      check("addr_nokey", 64'(addrn), e.val);
    end
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      check("out_lat1", 64'(bus1), e.val);
    end
    while (q3.size() > 0 && q3[0].due <= cyc) begin
      e = q3.pop_front();
      check("out_lat3", 64'(bus3), e.val);
    end
    while (qn.size() > 0 && qn[0].due <= cyc) begin
      e = qn.pop_front();
      check("out_nokey", 64'(busn), e.val);
    end
  endtask

  task automatic model_reset();
    m_xs = 0; m_ys = 0; m_sc = 0;
    m_mx = 0; m_my = 0; m_en = 0; m_vprev = 0;
  endtask

  // Reference model: texel colour from the ROM model is its own address.
  task automatic model_push();
    int dx, dy, ext, uu, vv, addr;
    bit inr, key;
    logic [11:0] col;
    exp_t e;
    dx   = int'(hcount_in) - m_xs;
    dy   = int'(vcount_in) - m_ys;
    ext  = 64 << m_sc;
    inr  = m_en && (int'(hcount_in) >= m_xs) && (dx < ext)
        && (int'(vcount_in) >= m_ys) && (dy < ext) && !hblnk_in && !vblnk_in;
    addr = 0;
    if (inr) begin
      uu = (dx >> m_sc) % 64;
      vv = (dy >> m_sc) % 64;
      if (m_mx) uu = 63 - uu;
      if (m_my) vv = 63 - vv;
      addr = vv * 64 + uu;
    end
    col = 12'(addr);
    key = (col == 12'h0FF);
    e.due = cyc + 1;
    e.val = 64'(addr);
    qa.push_back(e);
    e.due = cyc + 3;
    e.val = {25'b0, hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
             (inr && !key) ? col : rgb_in, inr && !key};
    q1.push_back(e);
    e.due = cyc + 5;
    q3.push_back(e);
    e.due = cyc + 3;
    e.val = {25'b0, hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
             inr ? col : rgb_in, inr};
    qn.push_back(e);
    if (vblnk_in && !m_vprev) begin
      m_xs = int'(xpos); m_ys = int'(ypos); m_sc = int'(scale);
      m_mx = mirror_x; m_my = mirror_y; m_en = enable;
    end
    m_vprev = vblnk_in;
  endtask

  task automatic apply_push(input int h, input int v, input bit hb, input bit vb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
    rgb_in    = 12'($urandom_range(0, 4095));
    model_push();
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb);
    @(negedge pclk);
    pop_all();
    apply_push(h, v, hb, vb);
  endtask

  task automatic scan(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) drive(h, v, 1'b0, 1'b0);
  endtask

  task automatic new_frame();
    drive(1100, 700, 1'b1, 1'b0);
    drive(0, 768, 1'b1, 1'b1);
    drive(1, 768, 1'b1, 1'b1);
    drive(2, 0, 1'b1, 1'b0);
  endtask

  task automatic set_cfg(input int x, input int y, input int sc, input bit mx,
                         input bit my, input bit en);
    xpos = 12'(x); ypos = 12'(y); scale = 2'(sc);
    mirror_x = mx; mirror_y = my; enable = en;
  endtask

  task automatic release_rst();
    exp_t e;
    @(negedge pclk);
    check_zero("rst_release");
    rst = 1'b1;
    e.val = 64'd0;
    for (int k = 1; k < 3; k++) begin e.due = cyc + k; q1.push_back(e); qn.push_back(e); end
    for (int k = 1; k < 5; k++) begin e.due = cyc + k; q3.push_back(e); end
    apply_push(0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
    set_cfg(100, 50, 0, 1'b0, 1'b0, 1'b1);
    model_reset();
    repeat (2) begin
      @(negedge pclk);
      check_zero("reset");
    end
    release_rst();

    // Enable latched at reset is 0: nothing drawn before the first capture
    scan(50, 98, 102);

    // Plain sprite at (100,50), including the colour key at texel (63,3)
    new_frame();
    scan(50, 98, 166);
    scan(53, 160, 165);
    scan(113, 98, 102);
    scan(114, 99, 101);

    // Scale x4: extent 256 pixels
    set_cfg(100, 50, 2, 1'b0, 1'b0, 1'b1);
    new_frame();
    scan(50, 98, 110);
    scan(60, 352, 358);
    scan(305, 99, 101);
    scan(306, 99, 101);

    // Both mirrors
    set_cfg(100, 50, 0, 1'b1, 1'b1, 1'b1);
    new_frame();
    scan(50, 99, 101);
    scan(113, 162, 164);

    // Mid-frame position change only takes effect next frame
    set_cfg(100, 50, 0, 1'b0, 1'b0, 1'b1);
    new_frame();
    scan(100, 98, 102);
    xpos = 12'd300;
    scan(200, 98, 102);
    scan(200, 298, 302);
    new_frame();
    scan(200, 98, 102);
    scan(200, 298, 302);

    // Right-edge clipping and an unreachable left edge
    set_cfg(2040, 50, 0, 1'b0, 1'b0, 1'b1);
    new_frame();
    scan(50, 2036, 2047);
    set_cfg(2100, 50, 0, 1'b0, 1'b0, 1'b1);
    new_frame();
    scan(50, 2036, 2047);

    // Asynchronous reset in the middle of a drawn line
    set_cfg(100, 50, 0, 1'b0, 1'b0, 1'b1);
    new_frame();
    scan(50, 98, 104);
    #2 rst = 1'b0;
    #1 check_zero("rst_async");
    qa.delete(); q1.delete(); q3.delete(); qn.delete();
    model_reset();
    repeat (2) begin
      @(negedge pclk);
      check_zero("rst_hold");
    end
    release_rst();
    scan(50, 98, 104);
    new_frame();
    scan(50, 98, 104);

    repeat (8) begin
      @(negedge pclk);
      pop_all();
    end
    check("drain", 64'(qa.size() + q1.size() + q3.size() + qn.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
